led_seq_ctrl: RTL

Memory-mapped sequencer that owns the board LED bank and animates it without CPU involvement. It sits on the same peripheral bus as the other memory-mapped devices: the CPU writes a pattern, a step period and a mode. The block then steps the pattern every PERIOD clocks (static, blink, rotate, bounce) and drives the active-low LED pins.

---
 rtl/led_seq_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: memory-mapped LED sequencer (static, blink, rotate, bounce) driving active-low pins.
// Define LED_SEQ_IRQ_EN to build the cycle-complete pending flag, CTRL[3] irq enable and irq output.
module led_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_7F40,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic [31:0] led_light
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

`ifdef LED_SEQ_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        return res;
    endfunction

    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] pattern_q, pattern_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cur_q, cur_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  step_q, step_d;
    logic        phase_q, phase_d;
    logic        dir_q, dir_d;
    logic [4:0]  bpos_q, bpos_d;   // steps taken in the current bounce direction

    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        in_win, wr_ctrl, wr_pattern, wr_period;
    logic        restart, running, step_evt, pend_bit;
    logic [31:0] last_cnt;
    mode_e       mode;
    logic        unused_offset_bits;

    // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both window bounds.
    assign offset             = Addr - BASE_ADDR;
    assign in_win             = offset < 32'd16;
    assign reg_sel            = offset[3:2];
    assign unused_offset_bits = ^offset[1:0];

    assign wr_ctrl    = WE && in_win && (reg_sel == 2'd0);
    assign wr_pattern = WE && in_win && (reg_sel == 2'd1);
    assign wr_period  = WE && in_win && (reg_sel == 2'd2);
    assign restart    = wr_ctrl || wr_pattern || wr_period;

    assign mode     = mode_e'(ctrl_q[1:0]);
    assign running  = ctrl_q[2] && (mode != MODE_STATIC);
    assign last_cnt = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
    assign step_evt = running && !restart && (cnt_q == last_cnt);

    // NOTE: every variable gets its hold value first so no path through the block infers a latch.
    always_comb begin
        ctrl_d    = (wr_ctrl && BE[0]) ? (Din[3:0] & CTRL_MASK) : ctrl_q;
        pattern_d = wr_pattern ? byte_merge(pattern_q, Din, BE) : pattern_q;
        period_d  = wr_period  ? byte_merge(period_q,  Din, BE) : period_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        phase_d   = phase_q;
        dir_d     = dir_q;
        bpos_d    = bpos_q;

        if (restart) begin
            cnt_d   = '0;
            step_d  = '0;
            phase_d = 1'b1;
            dir_d   = 1'b0;
            bpos_d  = '0;
            cur_d   = pattern_d;
        end else if (!running) begin
            cur_d = pattern_q;
            cnt_d = '0;
        end else if (step_evt) begin
            cnt_d  = '0;
            step_d = step_q + 8'd1;
            case (mode)
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                    cur_d   = phase_q ? 32'd0 : pattern_q;
                end
                MODE_ROTATE: cur_d = {cur_q[30:0], cur_q[31]};
                MODE_BOUNCE: begin
                    cur_d = dir_q ? {cur_q[0], cur_q[31:1]} : {cur_q[30:0], cur_q[31]};
                    if (bpos_q == 5'd30) begin
                        bpos_d = '0;
                        dir_d  = ~dir_q;
                    end else begin
                        bpos_d = bpos_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= '0;
            pattern_q <= '0;
            period_q  <= DEFAULT_PERIOD;
            cur_q     <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            phase_q   <= 1'b1;
            dir_q     <= 1'b0;
            bpos_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            bpos_q    <= bpos_d;
        end
    end

`ifdef LED_SEQ_IRQ_EN
    logic pend_q, irq_q, cycle_done, status_clr;

    assign status_clr = WE && in_win && (reg_sel == 2'd3) && (|BE) && Din[10];

    always_comb begin
        cycle_done = 1'b0;
        if (step_evt) begin
            case (mode)
                MODE_BLINK:  cycle_done = !phase_q;
                MODE_ROTATE: cycle_done = (step_q[4:0] == 5'd31);
                MODE_BOUNCE: cycle_done = dir_q && (bpos_q == 5'd30);
                default:     cycle_done = 1'b0;
            endcase
        end
    end

    // A completing cycle outranks a simultaneous software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= cycle_done ? 1'b1 : (status_clr ? 1'b0 : pend_q);
            irq_q  <= pend_q & ctrl_q[3];
        end
    end

    assign irq      = irq_q;
    assign pend_bit = pend_q;
`else
    assign pend_bit = 1'b0;
`endif

    always_comb begin
        Dout = '0;
        if (in_win) begin
            case (reg_sel)
                2'd0:    Dout = {28'd0, ctrl_q};
                2'd1:    Dout = pattern_q;
                2'd2:    Dout = period_q;
                default: Dout = {21'd0, pend_bit, dir_q, phase_q, step_q};
            endcase
        end
    end

    assign led_light = ~cur_q;

endmodule
